// File: rtl/data_mem_responder.sv
// data_mem_responder: services one load/store at a time from a word array
// with a fixed multi-cycle latency. While an access is in flight, a
// combinational stall holds the single-cycle core. Illegal, misaligned or
// out-of-range requests are flagged on req_err and never reach the array.
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_RD,
    input  logic              MEM_WR,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              done,
    output logic              req_err
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [3:0]        count_reg;
    logic              op_wr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic req;
    logic aligned;
    logic in_range;
    logic valid;
    logic accept;
    logic commit;

    // Request decode. DEPTH is a power of two, so "word index < DEPTH" is the
    // same as every index bit above the low IDX_W bits being zero.
    always_comb begin
        req      = MEM_RD | MEM_WR;
        aligned  = (addr[1:0] == 2'b00);
        in_range = (addr[ADDR_W-1:IDX_W+2] == '0);
        valid    = (MEM_RD ^ MEM_WR) & aligned & in_range;
        accept   = (state_reg == IDLE) & req & valid;
        commit   = (state_reg == BUSY) & (count_reg == 4'd0);
    end

    // Core-facing status: stall covers the request cycle and all BUSY cycles;
    // errors are only reported while idle, where the strobes are meaningful.
    always_comb begin
        stall   = accept | (state_reg == BUSY);
        req_err = (state_reg == IDLE) & req & ~valid;
        done    = (state_reg == DONE);
        rd_data = rd_data_reg;
    end

    // Access sequencer: capture the request in IDLE, count down in BUSY,
    // commit loads into rd_data on the last BUSY edge, then one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= 4'd0;
            op_wr_reg   <= 1'b0;
            idx_reg     <= '0;
            data_reg    <= '0;
            rd_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_wr_reg <= MEM_WR;
                        idx_reg   <= addr[IDX_W+1:2];
                        data_reg  <= wr_data;
                        count_reg <= LAT_M1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (commit) begin
                        state_reg <= DONE;
                        if (!op_wr_reg) begin
                            rd_data_reg <= mem[idx_reg];
                        end
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Array write port: a store lands only at its commit edge, and a reset on
    // that same edge aborts it. Contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_wr_reg) begin
            mem[idx_reg] <= data_reg;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table, reset-abort sequence, randomized
// accesses against a word-level reference model, and a LATENCY=1 build.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_rd, a_wr, a_stall, a_done, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_rd, b_wr, b_stall, b_done, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .MEM_RD(a_rd), .MEM_WR(a_wr), .addr(a_addr),
        .wr_data(a_wdata), .rd_data(a_rdata), .stall(a_stall), .done(a_done),
        .req_err(a_err)
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .MEM_RD(b_rd), .MEM_WR(b_wr), .addr(b_addr),
        .wr_data(b_wdata), .rd_data(b_rdata), .stall(b_stall), .done(b_done),
        .req_err(b_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain word array plus the last loaded value.
    logic [31:0] m_mem [256];
    bit          m_known [256];
    logic [31:0] m_rd;
    bit          m_rd_known;

    task automatic model_step(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, output bit err);
        int idx;
        err = !((rd != wr) && (a % 4 == 0) && (a / 4 < 256));
        if (!err) begin
            idx = int'(a / 4);
            if (wr) begin
                m_mem[idx]   = d;
                m_known[idx] = 1'b1;
            end else begin
                m_rd       = m_mem[idx];
                m_rd_known = m_known[idx];
            end
        end
    endtask

    // One access on the LATENCY=2 instance: request, 2 BUSY cycles with
    // scrambled inputs, then the DONE cycle.
    task automatic a_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit exp_err,
                            input logic [31:0] exp_rd, input bit chk_rd,
                            input string tag);
        @(posedge clk);
        #1;
        a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
        @(negedge clk);
        chk({tag, ".req_err"}, 32'(a_err), 32'(exp_err));
        chk({tag, ".req_stall"}, 32'(a_stall), 32'(!exp_err));
        chk({tag, ".req_done"}, 32'(a_done), 32'd0);
        if (exp_err) begin
            a_rd = 1'b0; a_wr = 1'b0;
            if (chk_rd) chk({tag, ".rd_hold"}, a_rdata, exp_rd);
            $display("[TB] %s rd=%0b wr=%0b addr=%h rejected", tag, rd, wr, a);
            return;
        end
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            a_rd = 1'($urandom); a_wr = 1'($urandom);
            a_addr = $urandom; a_wdata = $urandom;
            @(negedge clk);
            chk({tag, ".busy_stall"}, 32'(a_stall), 32'd1);
            chk({tag, ".busy_err"}, 32'(a_err), 32'd0);
            chk({tag, ".busy_done"}, 32'(a_done), 32'd0);
        end
        @(posedge clk);
        #1;
        a_rd = 1'b0; a_wr = 1'b0;
        @(negedge clk);
        chk({tag, ".done"}, 32'(a_done), 32'd1);
        chk({tag, ".done_stall"}, 32'(a_stall), 32'd0);
        if (chk_rd) chk({tag, ".rd_data"}, a_rdata, exp_rd);
        $display("[TB] %s rd=%0b wr=%0b addr=%h data=%h rd_data=%h", tag, rd, wr, a, d, a_rdata);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit   err;
        int   r;
        logic [31:0] ra;

        tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0,   32'h11111111, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 1'b1, 32'h4,   32'h22222222, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111};
        tbl[5]  = '{1'b1, 1'b0, 32'h4,   32'h0,        1'b0, 32'h22222222};
        tbl[6]  = '{1'b1, 1'b0, 32'h6,   32'h0,        1'b1, 32'h22222222};
        tbl[7]  = '{1'b0, 1'b1, 32'h400, 32'h99999999, 1'b1, 32'h22222222};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111};
        tbl[9]  = '{1'b0, 1'b1, 32'h8,   32'hA5A5A5A5, 1'b0, 32'h11111111};
        tbl[10] = '{1'b1, 1'b1, 32'h8,   32'h0BADF00D, 1'b1, 32'h11111111};
        tbl[11] = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 32'hA5A5A5A5};

        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        m_rd = 32'h0;
        m_rd_known = 1'b1;

        rst = 1'b1;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.rd_data", a_rdata, 32'h0);
        chk("reset.done", 32'(a_done), 32'd0);
        chk("reset.stall", 32'(a_stall), 32'd0);
        chk("reset.req_err", 32'(a_err), 32'd0);
        chk("reset_b.rd_data", b_rdata, 32'h0);
        chk("reset_b.stall", 32'(b_stall), 32'd0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, err);
            a_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                     tbl[i].exp_err, tbl[i].exp_rd, 1'b1, $sformatf("vec%0d", i));
        end

        // Reset during the first BUSY cycle aborts a store
        model_step(1'b0, 1'b1, 32'h20, 32'h12345678, err);
        a_access(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, m_rd, m_rd_known, "pre_abort");
        @(posedge clk);
        #1;
        a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("abort.req_stall", 32'(a_stall), 32'd1);
        @(posedge clk);
        #1;
        a_wr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort.stall", 32'(a_stall), 32'd0);
        chk("abort.done", 32'(a_done), 32'd0);
        chk("abort.rd_data", a_rdata, 32'h0);
        $display("[TB] abort store addr=00000020 data=cafef00d rd_data=%h", a_rdata);
        m_rd = 32'h0;
        m_rd_known = 1'b1;
        model_step(1'b1, 1'b0, 32'h20, 32'h0, err);
        a_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, m_rd, m_rd_known, "post_abort");

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            ra = 32'($urandom_range(0, 15)) * 4;
            if (r == 9) ra = ra + 32'($urandom_range(1, 3));
            if (r == 8) ra = 32'h400 + 32'($urandom_range(0, 255)) * 4;
            begin
                bit rd, wr;
                logic [31:0] d;
                rd = (r >= 4 && r <= 7) || r == 9 || ($urandom_range(0, 7) == 0);
                wr = (r <= 3) || r == 8 || (rd && $urandom_range(0, 5) == 0);
                d  = $urandom;
                model_step(rd, wr, ra, d, err);
                a_access(rd, wr, ra, d, err, m_rd, m_rd_known, $sformatf("rnd%0d", i));
            end
        end

        // LATENCY=1 instance: store, then a load with inputs toggled in BUSY
        @(posedge clk);
        #1;
        b_wr = 1'b1; b_addr = 32'hC; b_wdata = 32'h5A5AF00F;
        @(negedge clk);
        chk("lat1_st.req_stall", 32'(b_stall), 32'd1);
        @(posedge clk);
        #1;
        b_wr = 1'b0;
        @(negedge clk);
        chk("lat1_st.busy_stall", 32'(b_stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat1_st.done", 32'(b_done), 32'd1);
        chk("lat1_st.done_stall", 32'(b_stall), 32'd0);
        $display("[TB] lat1 store addr=0000000c data=5a5af00f");

        @(posedge clk);
        #1;
        b_rd = 1'b1; b_addr = 32'hC;
        @(negedge clk);
        chk("lat1_ld.req_stall", 32'(b_stall), 32'd1);
        @(posedge clk);
        #1;
        b_rd = 1'b0; b_wr = 1'b1; b_addr = 32'h0; b_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("lat1_ld.busy_stall", 32'(b_stall), 32'd1);
        chk("lat1_ld.busy_done", 32'(b_done), 32'd0);
        @(posedge clk);
        #1;
        b_wr = 1'b0;
        @(negedge clk);
        chk("lat1_ld.done", 32'(b_done), 32'd1);
        chk("lat1_ld.done_stall", 32'(b_stall), 32'd0);
        chk("lat1_ld.rd_data", b_rdata, 32'h5A5AF00F);
        $display("[TB] lat1 load addr=0000000c rd_data=%h", b_rdata);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
